// File: rtl/onehot_hold_decoder.sv
// Decodes an accepted index into a one-hot line held high for a programmable number of cycles.
// Latency: 1 cycle from accept to line assertion; lines switch directly between codes with no idle gap.
// Backpressure: in_ready depends only on internal state (never on in_valid); optional 1-entry skid buffer.
//
// Optional feature macro: ONEHOT_HOLD_SKID_EN
//   undefined : no buffering; in_ready is high in IDLE, or in HOLD on the last hold cycle only
//   defined   : 1-entry skid buffer (code + length); in_ready = !skid_full
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_code     encoded index (IN_W bits)
//   in_valid    in_code is valid this cycle
//   in_ready    block can accept in_code this cycle
//   hold_len    hold length in cycles; 0 is treated as 1; sampled at accept
//   out_onehot  registered one-hot line vector (2**IN_W bits), zero when idle
//   out_valid   high whenever out_onehot is non-zero
//   busy        high in HOLD or while the skid buffer is occupied
module onehot_hold_decoder #(
    parameter int IN_W   = 2,
    parameter int HOLD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_W-1:0]      in_code,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [HOLD_W-1:0]    hold_len,
    output logic [(2**IN_W)-1:0] out_onehot,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int OUT_W = 2**IN_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    logic [HOLD_W-1:0]  r_cnt;
    logic [OUT_W-1:0]   r_onehot;
    logic               r_out_valid;

    logic [HOLD_W-1:0]  w_len;
    logic [OUT_W-1:0]   w_dec;
    logic               w_last;
    logic               w_accept;

    // A zero hold length still produces a one-cycle strobe.
    assign w_len    = (hold_len == '0) ? HOLD_W'(1) : hold_len;
    assign w_dec    = {{(OUT_W-1){1'b0}}, 1'b1} << in_code;
    // cnt==0 never occurs in HOLD; treating it like the last cycle keeps the FSM from sticking.
    assign w_last   = (r_state == S_HOLD) && (r_cnt <= HOLD_W'(1));
    assign w_accept = in_valid && in_ready;

`ifdef ONEHOT_HOLD_SKID_EN
    logic               r_skid_full;
    logic [IN_W-1:0]    r_skid_code;
    logic [HOLD_W-1:0]  r_skid_len;
    logic [OUT_W-1:0]   w_skid_dec;

    assign w_skid_dec = {{(OUT_W-1){1'b0}}, 1'b1} << r_skid_code;
    assign in_ready   = !r_skid_full;
    assign busy       = (r_state == S_HOLD) || r_skid_full;
`else
    assign in_ready   = (r_state == S_IDLE) || w_last;
    assign busy       = (r_state == S_HOLD);
`endif

    assign out_onehot = r_onehot;
    assign out_valid  = r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_onehot    <= '0;
            r_out_valid <= 1'b0;
`ifdef ONEHOT_HOLD_SKID_EN
            r_skid_full <= 1'b0;
            r_skid_code <= '0;
            r_skid_len  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_HOLD;
                        r_cnt       <= w_len;
                        r_onehot    <= w_dec;
                        r_out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt - HOLD_W'(1);
`ifdef ONEHOT_HOLD_SKID_EN
                        // Mid-hold accepts park in the skid until the current line finishes.
                        if (w_accept) begin
                            r_skid_full <= 1'b1;
                            r_skid_code <= in_code;
                            r_skid_len  <= w_len;
                        end
`endif
                    end
`ifdef ONEHOT_HOLD_SKID_EN
                    // The parked code is older than anything on the input, so it goes first.
                    else if (r_skid_full) begin
                        r_cnt       <= r_skid_len;
                        r_onehot    <= w_skid_dec;
                        r_out_valid <= 1'b1;
                        r_skid_full <= 1'b0;
                    end
`endif
                    else if (w_accept) begin
                        // Direct reload: the line switches without an idle cycle.
                        r_cnt       <= w_len;
                        r_onehot    <= w_dec;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        r_onehot    <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_onehot    <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_hold_decoder.sv
module tb_onehot_hold_decoder;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [1:0] in_code  = '0;
    logic       in_valid = 1'b0;
    logic [3:0] hold_len = '0;
    logic       in_ready;
    logic [3:0] out_onehot;
    logic       out_valid;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] q_code[$];
    logic [3:0] q_len[$];

    onehot_hold_decoder #(.IN_W(2), .HOLD_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hold_len   (hold_len),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present the head of the pending queue.
    task automatic stream_start;
        if (q_code.size() > 0) begin
            in_code  = q_code[0];
            hold_len = q_len[0];
            in_valid = 1'b1;
        end
    endtask

    // Advance one clock; pop the head if it was handed over on this edge.
    task automatic stream_tick;
        bit acc;
        acc = in_valid && in_ready;
        tick();
        if (acc) begin
            void'(q_code.pop_front());
            void'(q_len.pop_front());
            if (q_code.size() > 0) begin
                in_code  = q_code[0];
                hold_len = q_len[0];
            end else begin
                in_valid = 1'b0;
                in_code  = 2'd0;
                hold_len = 4'd0;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        in_code  = 2'd3;   // ignored: no valid
        hold_len = 4'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (out_onehot !== 4'b0000) begin n_err++; $display("FAIL reset_oh[%0d]: got %b want 0000", i, out_onehot); end
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", i, out_valid); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b want 1", i, in_ready); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy); end
        end
        hold_len = 4'd0;
        in_code  = 2'd0;
    endtask

    task automatic test_single;
        logic [3:0] exp_oh  [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic       exp_rdy [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_bsy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        q_code.push_back(2'd2); q_len.push_back(4'd3);
        stream_start();
        for (int i = 0; i < 4; i++) begin
            stream_tick();
            if (i == 0) hold_len = 4'd15;   // change after accept must not stretch the hold
            n_vec++; if (out_onehot !== exp_oh[i]) begin n_err++; $display("FAIL single_oh[%0d]: got %b want %b", i, out_onehot, exp_oh[i]); end
            n_vec++; if (in_ready !== exp_rdy[i]) begin n_err++; $display("FAIL single_ready[%0d]: got %b want %b", i, in_ready, exp_rdy[i]); end
            n_vec++; if (out_valid !== (exp_oh[i] != 4'b0)) begin n_err++; $display("FAIL single_valid[%0d]: got %b want %b", i, out_valid, (exp_oh[i] != 4'b0)); end
            n_vec++; if (busy !== exp_bsy[i]) begin n_err++; $display("FAIL single_busy[%0d]: got %b want %b", i, busy, exp_bsy[i]); end
        end
        hold_len = 4'd0;
    endtask

    task automatic test_zero_len;
        logic [3:0] exp_oh [3] = '{4'b1000, 4'b0000, 4'b0000};
        q_code.push_back(2'd3); q_len.push_back(4'd0);
        stream_start();
        for (int i = 0; i < 3; i++) begin
            stream_tick();
            n_vec++; if (out_onehot !== exp_oh[i]) begin n_err++; $display("FAIL zero_oh[%0d]: got %b want %b", i, out_onehot, exp_oh[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_a [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic [3:0] exp_b [5] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000};
        q_code.push_back(2'd0); q_len.push_back(4'd2);
        q_code.push_back(2'd0); q_len.push_back(4'd2);
        stream_start();
        for (int i = 0; i < 5; i++) begin
            stream_tick();
            n_vec++; if (out_onehot !== exp_a[i]) begin n_err++; $display("FAIL b2b_same_oh[%0d]: got %b want %b", i, out_onehot, exp_a[i]); end
        end
        q_code.push_back(2'd1); q_len.push_back(4'd2);
        q_code.push_back(2'd3); q_len.push_back(4'd2);
        stream_start();
        for (int i = 0; i < 5; i++) begin
            stream_tick();
            n_vec++; if (out_onehot !== exp_b[i]) begin n_err++; $display("FAIL b2b_diff_oh[%0d]: got %b want %b", i, out_onehot, exp_b[i]); end
        end
    endtask

`ifndef ONEHOT_HOLD_SKID_EN
    // Second code is held on the input while the first line is mid-hold.
    task automatic test_stall;
        logic [3:0] exp_oh  [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0000};
        logic       exp_rdy [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        q_code.push_back(2'd1); q_len.push_back(4'd3);
        q_code.push_back(2'd2); q_len.push_back(4'd1);
        stream_start();
        for (int i = 0; i < 5; i++) begin
            stream_tick();
            n_vec++; if (out_onehot !== exp_oh[i]) begin n_err++; $display("FAIL stall_oh[%0d]: got %b want %b", i, out_onehot, exp_oh[i]); end
            n_vec++; if (in_ready !== exp_rdy[i]) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want %b", i, in_ready, exp_rdy[i]); end
        end
    endtask
`else
    task automatic test_skid;
        logic [3:0] exp_oh  [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        logic       exp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_bsy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        q_code.push_back(2'd1); q_len.push_back(4'd4);
        q_code.push_back(2'd2); q_len.push_back(4'd1);
        q_code.push_back(2'd3); q_len.push_back(4'd1);
        stream_start();
        for (int i = 0; i < 7; i++) begin
            stream_tick();
            n_vec++; if (out_onehot !== exp_oh[i]) begin n_err++; $display("FAIL skid_oh[%0d]: got %b want %b", i, out_onehot, exp_oh[i]); end
            n_vec++; if (in_ready !== exp_rdy[i]) begin n_err++; $display("FAIL skid_ready[%0d]: got %b want %b", i, in_ready, exp_rdy[i]); end
            n_vec++; if (busy !== exp_bsy[i]) begin n_err++; $display("FAIL skid_busy[%0d]: got %b want %b", i, busy, exp_bsy[i]); end
        end
    endtask
`endif

    task automatic test_async_reset;
        q_code.push_back(2'd2); q_len.push_back(4'd5);
        stream_start();
        stream_tick();
        n_vec++; if (out_onehot !== 4'b0100) begin n_err++; $display("FAIL areset_pre_oh: got %b want 0100", out_onehot); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_onehot !== 4'b0000) begin n_err++; $display("FAIL areset_oh: got %b want 0000", out_onehot); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", busy); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++; if (out_onehot !== 4'b0000) begin n_err++; $display("FAIL areset_after_oh[%0d]: got %b want 0000", i, out_onehot); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset_after_ready[%0d]: got %b want 1", i, in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_back_to_back();
`ifndef ONEHOT_HOLD_SKID_EN
        test_stall();
`else
        test_skid();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/onehot_hold_decoder.md
Name: onehot_hold_decoder

Overview:
- Sequential counterpart to the team's 4-to-2 priority encoder. It takes an encoded index plus valid and drives a one-hot line vector.
- Each accepted code asserts exactly one output line for a programmable number of cycles. The output is registered and uses a valid/ready handshake.
- Sits downstream of an encoder stage, driving per-channel enables or strobes.

Parameters:
- IN_W, 2, width of encoded index; output width is 2**IN_W (4 by default).
- HOLD_W, 4, width of the hold-length input.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_code  input  IN_W  encoded index to decode
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  block can accept in_code this cycle
- hold_len  input  HOLD_W  cycles to hold the line; sampled with the accepted code
- out_onehot  output  2**IN_W  registered one-hot line vector; all zeros when idle
- out_valid  output  1  high whenever out_onehot is non-zero
- busy  output  1  high in HOLD state or when the skid buffer is occupied

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, cnt=0, out_onehot=0, out_valid=0, busy=0, skid buffer empty. in_ready=1 once reset is released.
- Accept event: in_valid && in_ready on a rising edge.
- Effective length L = (hold_len==0) ? 1 : hold_len. This is sampled at accept and unaffected by later hold_len changes.
- States: IDLE, HOLD; cnt (HOLD_W bits) holds the remaining cycles.
- IDLE, on accept: next cycle state=HOLD, cnt=L, out_onehot = 1<<in_code, out_valid=1. Latency is 1 cycle from accept to line assertion.
- IDLE, no accept: outputs stay 0.
- HOLD with cnt>1: cnt decrements each cycle; out_onehot is unchanged.
- HOLD with cnt==1 and a pending code (direct accept this cycle, or skid entry): reload next cycle with the new code and new L. There is no idle gap; line switches directly (e.g. 0001 -> 0100). The skid entry takes precedence over direct input.
- HOLD with cnt==1 and nothing pending: next cycle state=IDLE, out_onehot=0, out_valid=0.
- Line assertion duration: exactly L cycles per accepted code. Same code back-to-back keeps the line high continuously for L1+L2 cycles.
- in_ready (no skid): 1 in IDLE; 1 in HOLD only when cnt==1; otherwise 0. Combinational from state and cnt only, never from in_valid.
- in_code is ignored whenever there is no accept.
- Output is never multi-hot: at most one bit of out_onehot is set in any cycle.
- busy = (state==HOLD) || skid_full.
- Reset asserted mid-HOLD: outputs go to 0 immediately (async), the pending code is discarded, and the block restarts in IDLE.

Optional Feature:
- Macro: ONEHOT_HOLD_SKID_EN.
- Defined: adds a 1-entry skid buffer holding code and L, with in_ready = !skid_full.
  - Accept in IDLE: decode directly as above.
  - Accept in HOLD with cnt>1: store in skid.
  - Accept in HOLD with cnt==1 and skid empty: load directly.
  - At cnt==1 with skid full: skid contents load next cycle and skid clears. in_ready is 0 that cycle.
  - Order of accepted codes is always preserved.
- Undefined: no buffer; in_ready follows the no-skid rule; busy reduces to state==HOLD.

Test Plan:
- Reset release, in_valid=0 for 5 cycles -> out_onehot=0000, out_valid=0, in_ready=1, busy=0 throughout.
- Single code: accept in_code=2, hold_len=3 from IDLE -> out_onehot=0100 for exactly 3 cycles starting 1 cycle after accept, then 0000; in_ready=0 for first 2 HOLD cycles, 1 on third.
- Zero length: in_code=3, hold_len=0 -> out_onehot=1000 for exactly 1 cycle.
- Back-to-back: code 0 L=2, then code 0 L=2 presented with in_valid held high -> bit0 high for 4 consecutive cycles, no gap. Repeat with codes 1 then 3 -> 0010 x2 then 1000 x2, no gap.
- Async reset while out_onehot=0100 with cnt=5 -> outputs 0 in the same cycle reset asserts. After release, IDLE with in_ready=1; prior code not resumed.
- With ONEHOT_HOLD_SKID_EN: accept code 1 L=4, then code 2 L=1 on next cycle (in_ready=1) -> 0010 for 4 cycles, then 0100 for 1 cycle. in_ready=0 while skid is full; a third code is stalled until skid drains.
